// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and helpers for the UART receive path.
//   ERR_W     : width of the saturating rejected-interval counter
//   win_bound : acceptance-window bound in clk cycles, computed as a
//               percentage of the nominal bit period CLK_FREQ / BAUD_RATE
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int ERR_W = 8;

    // The nominal bit period is truncated first, then scaled by the
    // percentage, so both window bounds derive from the same integer period.
    function automatic int unsigned win_bound(input int unsigned clk_freq,
                                              input int unsigned baud_rate,
                                              input int unsigned pct);
        return ((clk_freq / baud_rate) * pct) / 100;
    endfunction

endpackage

// File: rtl/uart_baud_meas_if.sv
// -----------------------------------------------------------------------------
// uart_baud_meas_if
// Bundles the serial input, the clear strobe and the measurement results of
// the auto-baud block.
//   rxd      : asynchronous serial line, idle high
//   clear    : synchronous clear of accumulator, lock and error count
//   sample   : last accepted interval (clk cycles), sample_v pulses on update
//   reject_v : pulses when an out-of-window interval is seen
//   period   : averaged bit period, period_v pulses on update
//   locked   : at least one period result since reset/clear
//   err_cnt  : saturating count of rejected intervals
// Modports: master drives rxd/clear and observes results; slave is the
// measurement block.
// -----------------------------------------------------------------------------
interface uart_baud_meas_if #(
    parameter int CNT_W = 16
) ();
    import uart_pkg::*;

    logic             rxd;
    logic             clear;
    logic [CNT_W-1:0] sample;
    logic             sample_v;
    logic             reject_v;
    logic [CNT_W-1:0] period;
    logic             period_v;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output rxd, clear,
        input  sample, sample_v, reject_v, period, period_v, locked, err_cnt
    );

    modport slave (
        input  rxd, clear,
        output sample, sample_v, reject_v, period, period_v, locked, err_cnt
    );

endinterface

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous bit.
//   clk     : destination clock
//   nrst    : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronised output
// RST_VAL sets the value both flops take in reset, so an idle-high line does
// not produce a spurious transition when reset is released.
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_baud_meas.sv
// -----------------------------------------------------------------------------
// uart_baud_meas
// Auto-baud measurement: times the interval between rxd transitions, reports
// intervals inside a tolerance window around the nominal bit period, counts
// out-of-window intervals as errors, and averages 2^AVG_LOG2 accepted
// intervals into a measured bit period with a lock flag.
//   clk   : clock
//   nrst  : asynchronous active-low reset
//   bus   : uart_baud_meas_if slave (rxd, clear in; results out)
// -----------------------------------------------------------------------------
module uart_baud_meas
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9_600,
    parameter int          CNT_W     = 16,
    parameter int unsigned LO_PCT    = 75,
    parameter int unsigned HI_PCT    = 125,
    parameter int unsigned AVG_LOG2  = 3
) (
    input  logic             clk,
    input  logic             nrst,
    uart_baud_meas_if.slave  bus
);

    localparam int unsigned LO     = win_bound(CLK_FREQ, BAUD_RATE, LO_PCT);
    localparam int unsigned HI     = win_bound(CLK_FREQ, BAUD_RATE, HI_PCT);
    localparam int          ACC_W  = CNT_W + int'(AVG_LOG2);
    localparam int          NACC_W = int'(AVG_LOG2) + 1;
    localparam int          AVG_N  = 2 ** AVG_LOG2;

    localparam logic [CNT_W-1:0]  LO_C    = CNT_W'(LO);
    localparam logic [CNT_W-1:0]  HI_C    = CNT_W'(HI);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [NACC_W-1:0] NACC_LAST = NACC_W'(AVG_N - 1);

    // The all-ones count is reserved as the "idle / unmeasured" marker, so
    // the window must stay strictly below it and must not start at zero.
    if ((longint'(HI) >= ((longint'(1) << CNT_W) - 1)) || (LO == 0)) begin : g_bad_window
        $error("uart_baud_meas: acceptance window does not fit the interval counter");
    end

    logic              w_rxd_s;
    logic              r_rxd_d;
    logic              w_edge;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_sat;
    logic              w_in_win;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_sum;
    logic [NACC_W-1:0] r_nacc;
    logic              w_last;

    logic [CNT_W-1:0]  r_sample;
    logic              r_sample_v;
    logic              r_reject_v;
    logic [CNT_W-1:0]  r_period;
    logic              r_period_v;
    logic              r_locked;
    logic [ERR_W-1:0]  r_err_cnt;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .i_d  (bus.rxd),
        .o_q  (w_rxd_s)
    );

    // Delayed copy of the synchronised line for transition detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rxd_d <= 1'b1;
        end else begin
            r_rxd_d <= w_rxd_s;
        end
    end

    assign w_edge   = (w_rxd_s != r_rxd_d);
    assign w_sat    = (r_cnt == CNT_MAX);
    assign w_in_win = (r_cnt >= LO_C) && (r_cnt <= HI_C);
    assign w_sum    = r_acc + ACC_W'(r_cnt);
    assign w_last   = (r_nacc == NACC_LAST);

    // Interval counter restarts at 1 on a transition, so at the next
    // transition it holds the number of cycles in between. It sticks at
    // all-ones after a long idle gap, which marks the interval as unmeasured.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= CNT_MAX;
        end else if (w_edge) begin
            r_cnt <= CNT_W'(1);
        end else if (!w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Classification and averaging. clear has priority over a coinciding
    // transition. A saturated counter both discards any partial average and
    // suppresses classification of the transition that ends the idle gap.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc      <= '0;
            r_nacc     <= '0;
            r_sample   <= '0;
            r_sample_v <= 1'b0;
            r_reject_v <= 1'b0;
            r_period   <= '0;
            r_period_v <= 1'b0;
            r_locked   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_sample_v <= 1'b0;
            r_reject_v <= 1'b0;
            r_period_v <= 1'b0;
            if (bus.clear) begin
                r_acc     <= '0;
                r_nacc    <= '0;
                r_locked  <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_sat) begin
                r_acc  <= '0;
                r_nacc <= '0;
            end else if (w_edge) begin
                if (w_in_win) begin
                    r_sample   <= r_cnt;
                    r_sample_v <= 1'b1;
                    if (w_last) begin
                        r_period   <= CNT_W'(w_sum >> AVG_LOG2);
                        r_period_v <= 1'b1;
                        r_locked   <= 1'b1;
                        r_acc      <= '0;
                        r_nacc     <= '0;
                    end else begin
                        r_acc  <= w_sum;
                        r_nacc <= r_nacc + NACC_W'(1);
                    end
                end else begin
                    r_reject_v <= 1'b1;
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + ERR_W'(1);
                    end
                end
            end
        end
    end

    assign bus.sample   = r_sample;
    assign bus.sample_v = r_sample_v;
    assign bus.reject_v = r_reject_v;
    assign bus.period   = r_period;
    assign bus.period_v = r_period_v;
    assign bus.locked   = r_locked;
    assign bus.err_cnt  = r_err_cnt;

endmodule
